control_sequencer: RTL

- Microcoded control unit for the SAP-U datapath.
- Runs a T-step counter, keeps the carry/zero flag register, and decodes opcode, step and flags into the control word for RAM/MAR, PC, IR, A, B, ALU and OUT.
- It sits directly upstream of the RAM stage and produces its load_mar_reg_n, write_enable and bus_enable_n strobes.

---
 rtl/sap_pkg.sv | 53 +++++
 rtl/microcode_rom.sv | 86 ++++++++
 rtl/control_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared opcodes, control-word layout and state encoding for the SAP-U sequencer
package sap_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CW_W          = 16;
  localparam int CW_HALT       = 15;
  localparam int CW_LOAD_MAR_N = 14;
  localparam int CW_WRITE_EN   = 13;
  localparam int CW_BUS_EN_N   = 12;
  localparam int CW_IR_IN      = 11;
  localparam int CW_IR_OUT     = 10;
  localparam int CW_A_IN       = 9;
  localparam int CW_A_OUT      = 8;
  localparam int CW_B_IN       = 7;
  localparam int CW_ALU_OUT    = 6;
  localparam int CW_ALU_SUB    = 5;
  localparam int CW_OUT_IN     = 4;
  localparam int CW_PC_EN      = 3;
  localparam int CW_PC_OUT     = 2;
  localparam int CW_PC_JUMP    = 1;
  localparam int CW_FLAGS_IN   = 0;

  typedef logic [CW_W-1:0] cw_t;

  // Only the two RAM-side active-low strobes sit at 1 when idle.
  localparam cw_t CW_INACTIVE = cw_t'((1 << CW_LOAD_MAR_N) | (1 << CW_BUS_EN_N));

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_PROG   = 2'd2
  } state_t;

  function automatic int last_step(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: return 3;
      OP_ADD, OP_SUB: return 4;
      default:        return 2;
    endcase
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational (opcode, step, flags) to control-word lookup
module microcode_rom
  import sap_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [STEP_W-1:0]   step,
  input  logic                carry,
  input  logic                zero,
  output cw_t                 cw
);

  always_comb begin
    cw = CW_INACTIVE;
    case (step)
      STEP_W'(0): begin
        cw[CW_PC_OUT]     = 1'b1;
        cw[CW_LOAD_MAR_N] = 1'b0;
      end
      STEP_W'(1): begin
        cw[CW_BUS_EN_N] = 1'b0;
        cw[CW_IR_IN]    = 1'b1;
        cw[CW_PC_EN]    = 1'b1;
      end
      STEP_W'(2): begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IR_OUT]     = 1'b1;
            cw[CW_LOAD_MAR_N] = 1'b0;
          end
          OP_LDI: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_A_IN]   = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_JUMP] = 1'b1;
          end
          OP_JC: begin
            cw[CW_IR_OUT]  = carry;
            cw[CW_PC_JUMP] = carry;
          end
          OP_JZ: begin
            cw[CW_IR_OUT]  = zero;
            cw[CW_PC_JUMP] = zero;
          end
          OP_OUT: begin
            cw[CW_A_OUT]  = 1'b1;
            cw[CW_OUT_IN] = 1'b1;
          end
          OP_HLT: cw[CW_HALT] = 1'b1;
          default: ;
        endcase
      end
      STEP_W'(3): begin
        case (opcode)
          OP_LDA: begin
            cw[CW_BUS_EN_N] = 1'b0;
            cw[CW_A_IN]     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_BUS_EN_N] = 1'b0;
            cw[CW_B_IN]     = 1'b1;
          end
          OP_STA: begin
            cw[CW_A_OUT]    = 1'b1;
            cw[CW_WRITE_EN] = 1'b1;
          end
          default: ;
        endcase
      end
      STEP_W'(4): begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw[CW_ALU_OUT]  = 1'b1;
          cw[CW_A_IN]     = 1'b1;
          cw[CW_FLAGS_IN] = 1'b1;
          cw[CW_ALU_SUB]  = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T-step counter, run/halt/prog FSM and flag register around the microcode ROM
module control_sequencer
  import sap_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3,
  parameter int MAX_STEP = 4
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic                prog_mode,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_carry,
  input  logic                alu_zero,
  output logic                halt,
  output logic                load_mar_reg_n,
  output logic                write_enable,
  output logic                bus_enable_n,
  output logic                ir_in,
  output logic                ir_out,
  output logic                a_in,
  output logic                a_out,
  output logic                b_in,
  output logic                alu_out,
  output logic                alu_sub,
  output logic                out_in,
  output logic                pc_en,
  output logic                pc_out,
  output logic                pc_jump,
  output logic                flags_in,
  output logic                carry_flag,
  output logic                zero_flag,
  output logic [STEP_W-1:0]   step
);

  state_t              state, state_nxt;
  logic [STEP_W-1:0]   step_q, step_nxt;
  logic                carry_q, zero_q;
  cw_t                 rom_cw, cw;

  microcode_rom #(
    .OPCODE_W (OPCODE_W),
    .STEP_W   (STEP_W)
  ) u_rom (
    .opcode (opcode),
    .step   (step_q),
    .carry  (carry_q),
    .zero   (zero_q),
    .cw     (rom_cw)
  );

  // Reset lands directly in PROG when the dipswitch programmer is active.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state  <= prog_mode ? ST_PROG : ST_RUN;
      step_q <= '0;
    end else begin
      state  <= state_nxt;
      step_q <= step_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step_q;
    if (prog_mode) begin
      state_nxt = ST_PROG;
      step_nxt  = '0;
    end else begin
      case (state)
        ST_PROG: begin
          state_nxt = ST_RUN;
          step_nxt  = '0;
        end
        ST_HALTED: step_nxt = STEP_W'(2);
        default: begin
          state_nxt = ST_RUN;
          if (step_q > STEP_W'(MAX_STEP)) begin
            step_nxt = '0;
          end else if (step_q == STEP_W'(2) && opcode == OP_HLT) begin
            state_nxt = ST_HALTED;
            step_nxt  = STEP_W'(2);
          end else if (step_q >= STEP_W'(last_step(opcode))) begin
            step_nxt = '0;
          end else begin
            step_nxt = step_q + STEP_W'(1);
          end
        end
      endcase
    end
  end

  // Reset level masks the word combinationally so nothing strobes while clear_n is low.
  always_comb begin
    cw = CW_INACTIVE;
    if (clear_n) begin
      case (state)
        ST_RUN:    cw = rom_cw;
        ST_HALTED: cw[CW_HALT] = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (cw[CW_FLAGS_IN]) begin
      carry_q <= alu_carry;
      zero_q  <= alu_zero;
    end
  end

  assign halt           = cw[CW_HALT];
  assign load_mar_reg_n = cw[CW_LOAD_MAR_N];
  assign write_enable   = cw[CW_WRITE_EN];
  assign bus_enable_n   = cw[CW_BUS_EN_N];
  assign ir_in          = cw[CW_IR_IN];
  assign ir_out         = cw[CW_IR_OUT];
  assign a_in           = cw[CW_A_IN];
  assign a_out          = cw[CW_A_OUT];
  assign b_in           = cw[CW_B_IN];
  assign alu_out        = cw[CW_ALU_OUT];
  assign alu_sub        = cw[CW_ALU_SUB];
  assign out_in         = cw[CW_OUT_IN];
  assign pc_en          = cw[CW_PC_EN];
  assign pc_out         = cw[CW_PC_OUT];
  assign pc_jump        = cw[CW_PC_JUMP];
  assign flags_in       = cw[CW_FLAGS_IN];
  assign carry_flag     = carry_q;
  assign zero_flag      = zero_q;
  assign step           = step_q;

endmodule
